mmss_clock_ctrl: RTL and testbench
==================================

Name: mmss_clock_ctrl

Overview:
Minutes:seconds timekeeping controller for the lab clock display. It sequences four cascaded BCD digit counters: seconds-ones, seconds-tens, minutes-ones and minutes-tens. For each digit it generates the per-digit clock-enable and load/clear strobes from a 1 Hz tick, and applies carry and wrap rules. A mode/increment button interface lets the user set minutes and seconds while time is frozen; outputs feed the 7-segment display driver.

Parameters:
SEC_TENS_MAX, 5, terminal value of seconds-tens digit (seconds wrap at SEC_TENS_MAX:9)
MIN_TENS_MAX, 5, terminal value of minutes-tens digit (minutes wrap at MIN_TENS_MAX:9)
DIG_W, 4, width of each BCD digit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle 1 Hz strobe from prescaler
mode_btn  in  1  one-cycle debounced pulse; advances mode
inc_btn  in  1  one-cycle debounced pulse; increments selected field in set modes
sec_lo  out  DIG_W  seconds ones digit, 0..9
sec_hi  out  DIG_W  seconds tens digit, 0..SEC_TENS_MAX
min_lo  out  DIG_W  minutes ones digit, 0..9
min_hi  out  DIG_W  minutes tens digit, 0..MIN_TENS_MAX
mode  out  2  00 RUN, 01 SET_MIN, 10 SET_SEC
blink  out  1  display blank request for selected field in set modes
hour_pulse  out  1  one-cycle pulse when time wraps from max:max to 00:00

Behaviour:
- Reset: clk and rst are as stated above (rst synchronous, active-high, on clk). rst high at any edge, including mid-increment or mid-set: all digits 0, mode=RUN, blink=0, hour_pulse=0. Reset has priority over every other input.
- FSM: RUN -> SET_MIN -> SET_SEC -> RUN. Each transition occurs on a mode_btn pulse. Encoding 11 is unreachable; if ever entered, the next state is RUN.
- RUN mode, tick=1: sec_lo increments.
  - sec_lo==9: sec_lo clears to 0 and sec_hi is enabled.
  - sec_hi==SEC_TENS_MAX and sec_lo==9: both clear and min_lo is enabled; same rule cascades through min_lo/min_hi.
  - All four digits at max: all clear to 0 and hour_pulse=1 in the same cycle the digits show 00:00.
- Enables: per-digit enable = tick AND all lower digits at terminal value; per-digit clear = enable AND own digit at terminal value. Both are combinational from registered digits; all digits update on the clk edge that samples tick. Latency is 1 cycle from tick to new value.
- Set modes freeze time: tick is ignored and hour_pulse stays 0.
- SET_MIN, inc_btn: minutes increment by 1 with carry min_lo->min_hi only. Wrap from max:9 to 00 without touching seconds and without pulsing hour_pulse.
- SET_SEC, inc_btn: seconds increment by 1 with carry sec_lo->sec_hi only. Wrap to 00 without carrying into minutes.
- mode_btn and inc_btn in the same cycle: mode change wins; the inc is dropped.
- tick coincident with mode_btn in RUN: the tick is applied and the mode advances, both on the same edge.
- blink: 0 in RUN. In set modes it toggles on each tick, and is cleared to 0 on any mode change or inc_btn so the field is immediately visible.
- Out-of-range digits (not reachable from reset) clear to 0 on their next enable.

Decomposition:
- Shared package mmss_pkg: mode encodings MODE_RUN/MODE_SET_MIN/MODE_SET_SEC, BCD_MAX_ONES=9, DIG_W.
- One sub-module, bcd_digit_ctr (params DIG_W, MAX), instantiated four times.
  - Ports: clk, rst, en, clr, q, at_max.
  - Behaviour: synchronous reset; en&clr -> 0; en -> q+1 by explicit ripple-XOR increment logic; at_max combinational.
- mmss_clock_ctrl contains the FSM, enable/clear generation, blink and hour_pulse.

Test Plan:
- Reset then 10 ticks in RUN -> display 00:10 (sec_hi=1, sec_lo=0); each digit changes exactly 1 cycle after its tick.
- Preload to 59:58 via set modes, return to RUN, 2 ticks -> 59:59 then 00:00 with hour_pulse=1 for exactly one cycle.
- Minutes set:
  - Steps: mode_btn once (SET_MIN), 61 inc_btn pulses with interleaved ticks.
  - Response: min=01, seconds unchanged, no hour_pulse, ticks do not advance time.
- Seconds set:
  - Steps: SET_SEC from 00:59, inc_btn.
  - Response: 00:00, minutes untouched; blink toggles on ticks and is cleared to 0 on that inc_btn.
- mode_btn and inc_btn in the same cycle while in SET_MIN -> mode becomes SET_SEC, minutes unchanged.
- rst asserted at 37:42 in SET_SEC, coincident with inc_btn and tick -> next cycle 00:00, mode=RUN, blink=0, hour_pulse=0.

Source files
------------

// File: rtl/mmss_pkg.sv
// rtl/mmss_pkg.sv - shared mode encodings and digit constants for the mm:ss clock
package mmss_pkg;

  localparam int DIG_W        = 4;
  localparam int BCD_MAX_ONES = 9;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_MIN = 2'b01,
    MODE_SET_SEC = 2'b10,
    MODE_BAD     = 2'b11
  } mode_e;

  // Illegal encoding recovers to RUN rather than sticking.
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_RUN:     next_mode = MODE_SET_MIN;
      MODE_SET_MIN: next_mode = MODE_SET_SEC;
      default:      next_mode = MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/mmss_clock_ctrl_if.sv
// rtl/mmss_clock_ctrl_if.sv - button/tick inputs and display outputs of the mm:ss clock
interface mmss_clock_ctrl_if #(
  parameter int DIG_W = mmss_pkg::DIG_W
);
  import mmss_pkg::*;

  logic             tick;
  logic             mode_btn;
  logic             inc_btn;
  logic [DIG_W-1:0] sec_lo;
  logic [DIG_W-1:0] sec_hi;
  logic [DIG_W-1:0] min_lo;
  logic [DIG_W-1:0] min_hi;
  logic [1:0]       mode;
  logic             blink;
  logic             hour_pulse;

  modport master (
    output tick, mode_btn, inc_btn,
    input  sec_lo, sec_hi, min_lo, min_hi, mode, blink, hour_pulse
  );

  modport slave (
    input  tick, mode_btn, inc_btn,
    output sec_lo, sec_hi, min_lo, min_hi, mode, blink, hour_pulse
  );

endinterface

// File: rtl/bcd_digit_ctr.sv
// rtl/bcd_digit_ctr.sv - one BCD digit with enable/clear and a terminal-value flag
module bcd_digit_ctr #(
  parameter int DIG_W = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [DIG_W-1:0] q,
  output logic             at_max
);

  logic [DIG_W-1:0] q_q;
  logic [DIG_W-1:0] q_d;
  logic [DIG_W-1:0] carry;
  logic [DIG_W-1:0] inc_val;

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < DIG_W; i++) begin
      carry[i] = q_q[i-1] & carry[i-1];
    end
    inc_val = q_q ^ carry;
  end

  // ">=" so an out-of-range value is treated as terminal and clears on its next enable.
  assign at_max = (q_q >= DIG_W'(MAX));

  always_comb begin
    q_d = q_q;
    if (en && clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = inc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mmss_clock_ctrl.sv
// rtl/mmss_clock_ctrl.sv - mm:ss timekeeping: mode FSM, digit enable/clear cascade, blink, hour pulse
module mmss_clock_ctrl #(
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 5,
  parameter int DIG_W        = mmss_pkg::DIG_W
) (
  input  logic               clk,
  input  logic               rst,
  mmss_clock_ctrl_if.slave   bus
);
  import mmss_pkg::*;

  mode_e            mode_q;
  logic             blink_q;
  logic             hour_pulse_q;
  logic             hour_pulse_d;

  logic             tick_run;
  logic             inc_eff;
  logic             en_s0, en_s1, en_m0, en_m1;
  logic             clr_s0, clr_s1, clr_m0, clr_m1;
  logic             max_s0, max_s1, max_m0, max_m1;
  logic [DIG_W-1:0] s0, s1, m0, m1;

  // A coincident mode press swallows the increment.
  assign tick_run = bus.tick && (mode_q == MODE_RUN);
  assign inc_eff  = bus.inc_btn && !bus.mode_btn;

  assign en_s0 = tick_run || (inc_eff && mode_q == MODE_SET_SEC);
  assign en_s1 = en_s0 && max_s0;
  assign en_m0 = (tick_run && max_s0 && max_s1) || (inc_eff && mode_q == MODE_SET_MIN);
  assign en_m1 = en_m0 && max_m0;

  assign clr_s0 = en_s0 && max_s0;
  assign clr_s1 = en_s1 && max_s1;
  assign clr_m0 = en_m0 && max_m0;
  assign clr_m1 = en_m1 && max_m1;

  assign hour_pulse_d = tick_run && max_s0 && max_s1 && max_m0 && max_m1;

  bcd_digit_ctr #(.DIG_W(DIG_W), .MAX(BCD_MAX_ONES)) u_sec_lo (
    .clk(clk), .rst(rst), .en(en_s0), .clr(clr_s0), .q(s0), .at_max(max_s0)
  );
  bcd_digit_ctr #(.DIG_W(DIG_W), .MAX(SEC_TENS_MAX)) u_sec_hi (
    .clk(clk), .rst(rst), .en(en_s1), .clr(clr_s1), .q(s1), .at_max(max_s1)
  );
  bcd_digit_ctr #(.DIG_W(DIG_W), .MAX(BCD_MAX_ONES)) u_min_lo (
    .clk(clk), .rst(rst), .en(en_m0), .clr(clr_m0), .q(m0), .at_max(max_m0)
  );
  bcd_digit_ctr #(.DIG_W(DIG_W), .MAX(MIN_TENS_MAX)) u_min_hi (
    .clk(clk), .rst(rst), .en(en_m1), .clr(clr_m1), .q(m1), .at_max(max_m1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_RUN;
      blink_q      <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      hour_pulse_q <= hour_pulse_d;
      if (bus.mode_btn) begin
        mode_q  <= next_mode(mode_q);
        blink_q <= 1'b0;
      end else begin
        case (mode_q)
          MODE_SET_MIN, MODE_SET_SEC: begin
            if (bus.inc_btn) begin
              blink_q <= 1'b0;
            end else if (bus.tick) begin
              blink_q <= ~blink_q;
            end
          end
          MODE_RUN: begin
            blink_q <= 1'b0;
          end
          default: begin
            mode_q  <= MODE_RUN;
            blink_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sec_lo     = s0;
  assign bus.sec_hi     = s1;
  assign bus.min_lo     = m0;
  assign bus.min_hi     = m1;
  assign bus.mode       = mode_q;
  assign bus.blink      = blink_q;
  assign bus.hour_pulse = hour_pulse_q;

endmodule

// File: tb/tb_mmss_clock_ctrl.sv
// tb/tb_mmss_clock_ctrl.sv - scoreboard bench for mmss_clock_ctrl against a seconds/minutes arithmetic model
module tb_mmss_clock_ctrl;

  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_TENS_MAX = 5;
  localparam int SEC_MOD      = (SEC_TENS_MAX + 1) * 10;
  localparam int MIN_MOD      = (MIN_TENS_MAX + 1) * 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mmss_clock_ctrl_if #(.DIG_W(4)) bus ();

  mmss_clock_ctrl #(
    .SEC_TENS_MAX(SEC_TENS_MAX),
    .MIN_TENS_MAX(MIN_TENS_MAX),
    .DIG_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sl;
    int sh;
    int ml;
    int mh;
    int md;
    int bl;
    int hp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_min  = 0;
  int m_sec  = 0;
  int m_mode = 0;
  int m_blk  = 0;
  int m_hp   = 0;

  task automatic check(input string name, input logic [7:0] act, input int expv);
    checks++;
    if (act !== 8'(expv)) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: registered outputs present a new value every cycle, one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sec_lo", bus.sec_lo, e.sl);
        check("sec_hi", bus.sec_hi, e.sh);
        check("min_lo", bus.min_lo, e.ml);
        check("min_hi", bus.min_hi, e.mh);
        check("mode", 8'(bus.mode), e.md);
        check("blink", 8'(bus.blink), e.bl);
        check("hour_pulse", 8'(bus.hour_pulse), e.hp);
      end
    end
  end

  task automatic model(input bit t, input bit mb, input bit ib, input bit r);
    int total;
    bit inc_ok;
    if (r) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_blk = 0; m_hp = 0;
      return;
    end
    m_hp   = 0;
    inc_ok = ib && !mb;
    if (m_mode == 0 && t) begin
      total = m_min * 60 + m_sec + 1;
      if (total == MIN_MOD * 60) begin
        total = 0;
        m_hp  = 1;
      end
      m_min = total / 60;
      m_sec = total % 60;
    end
    if (m_mode == 1 && inc_ok) m_min = (m_min + 1) % MIN_MOD;
    if (m_mode == 2 && inc_ok) m_sec = (m_sec + 1) % SEC_MOD;
    if (mb || m_mode == 0 || ib) m_blk = 0;
    else if (t) m_blk = 1 - m_blk;
    if (mb) m_mode = (m_mode + 1) % 3;
  endtask

  task automatic step(input bit t, input bit mb, input bit ib, input bit r);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus.tick     = t;
    bus.mode_btn = mb;
    bus.inc_btn  = ib;
    model(t, mb, ib, r);
    e.sl = m_sec % 10;
    e.sh = m_sec / 10;
    e.ml = m_min % 10;
    e.mh = m_min / 10;
    e.md = m_mode;
    e.bl = m_blk;
    e.hp = m_hp;
    exp_q.push_back(e);
  endtask

  // Leaves the clock frozen in SET_SEC at mm:ss.
  task automatic preload(input int mm, input int ss);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (mm) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (ss) step(0, 0, 1, 0);
  endtask

  initial begin
    bus.tick     = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (10) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    preload(59, 58);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 61; i++) begin
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);
    end
    step(0, 1, 1, 0);
    step(1, 0, 0, 0);

    step(0, 0, 0, 1);
    repeat (59) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);

    preload(37, 42);
    step(1, 0, 1, 1);
    step(0, 0, 0, 0);

    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0);
    end
    step(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
